// File: rtl/tim_ctrl.sv
// Timer control block: bus register file, IDLE/RUN/HALT sequencer and update-event handling.
// Optional feature macro TIM_CTRL_PRELOAD_EN: PSC/ARR/CCR1/CCR2 are double-buffered and go active on update events.
module tim_ctrl #(
  parameter logic [15:0] ARR_RST = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_sel,
  input  logic        bus_we,
  input  logic [2:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  input  logic        tim_done,
  input  logic [15:0] tim_cnt,
  output logic        timer_en,
  output logic        countdown,
  output logic [15:0] TIM_PSC,
  output logic [15:0] TIM_ARR,
  output logic [15:0] TIM_CCR1,
  output logic [15:0] TIM_CCR2,
  output logic        irq
);

  // state   | meaning
  // IDLE    | timer stopped, waiting for CR.EN write
  // RUN     | timer enabled
  // HALT    | stopped after one-pulse completion, restart needs CR.EN write
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [2:0] A_CR   = 3'd0;
  localparam logic [2:0] A_SR   = 3'd1;
  localparam logic [2:0] A_PSC  = 3'd2;
  localparam logic [2:0] A_ARR  = 3'd3;
  localparam logic [2:0] A_CCR1 = 3'd4;
  localparam logic [2:0] A_CCR2 = 3'd5;
  localparam logic [2:0] A_CNT  = 3'd6;
  localparam logic [2:0] A_EGR  = 3'd7;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cr_q, cr_d;
  logic        uif_q, uif_d;
  logic [15:0] psc_q, psc_d;
  logic [15:0] arr_q, arr_d;
  logic [15:0] ccr1_q, ccr1_d;
  logic [15:0] ccr2_q, ccr2_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q;

  logic        wr_en, rd_en;
  logic        cr_wr, sr_wr, psc_wr, arr_wr, ccr1_wr, ccr2_wr, egr_ug;
  logic        run_done, upd_evt;
  logic [15:0] wdata16;
  logic [15:0] psc_rd, arr_rd, ccr1_rd, ccr2_rd;
  logic        unused_wdata_hi;

  assign wdata16         = bus_wdata[15:0];
  assign unused_wdata_hi = ^bus_wdata[31:16];

  assign wr_en   = bus_sel & bus_we;
  assign rd_en   = bus_sel & ~bus_we;
  assign cr_wr   = wr_en && (bus_addr == A_CR);
  assign sr_wr   = wr_en && (bus_addr == A_SR);
  assign psc_wr  = wr_en && (bus_addr == A_PSC);
  assign arr_wr  = wr_en && (bus_addr == A_ARR);
  assign ccr1_wr = wr_en && (bus_addr == A_CCR1);
  assign ccr2_wr = wr_en && (bus_addr == A_CCR2);
  assign egr_ug  = wr_en && (bus_addr == A_EGR) && bus_wdata[0];

  // tim_done outside RUN is dropped entirely; UG and tim_done together are one event.
  assign run_done = (state_q == ST_RUN) && tim_done;
  assign upd_evt  = run_done || egr_ug;

  always_comb begin
    state_d = state_q;
    cr_d    = cr_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (cr_wr) begin
          cr_d = wdata16[3:0];
          if (wdata16[0]) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cr_wr) begin
          cr_d = wdata16[3:0];
          if (!wdata16[0]) state_d = ST_IDLE;
        end else if (tim_done && cr_q[2]) begin
          cr_d[0] = 1'b0;
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cr_d[0] = 1'b0;
      end
    endcase
  end

  // Set beats clear when both land on the same edge.
  always_comb begin
    uif_d = uif_q;
    if (sr_wr && wdata16[0]) uif_d = 1'b0;
    if (upd_evt)             uif_d = 1'b1;
  end

`ifdef TIM_CTRL_PRELOAD_EN
  logic [15:0] psc_sh_q, psc_sh_d;
  logic [15:0] arr_sh_q, arr_sh_d;
  logic [15:0] ccr1_sh_q, ccr1_sh_d;
  logic [15:0] ccr2_sh_q, ccr2_sh_d;

  always_comb begin
    psc_sh_d  = psc_wr  ? wdata16 : psc_sh_q;
    arr_sh_d  = arr_wr  ? wdata16 : arr_sh_q;
    ccr1_sh_d = ccr1_wr ? wdata16 : ccr1_sh_q;
    ccr2_sh_d = ccr2_wr ? wdata16 : ccr2_sh_q;
  end

  // Active copies take the pre-edge shadow, so a coincident write waits for the next update.
  always_comb begin
    psc_d  = upd_evt ? psc_sh_q  : psc_q;
    arr_d  = upd_evt ? arr_sh_q  : arr_q;
    ccr1_d = upd_evt ? ccr1_sh_q : ccr1_q;
    ccr2_d = upd_evt ? ccr2_sh_q : ccr2_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      psc_sh_q  <= 16'h0000;
      arr_sh_q  <= ARR_RST;
      ccr1_sh_q <= 16'h0000;
      ccr2_sh_q <= 16'h0000;
    end else begin
      psc_sh_q  <= psc_sh_d;
      arr_sh_q  <= arr_sh_d;
      ccr1_sh_q <= ccr1_sh_d;
      ccr2_sh_q <= ccr2_sh_d;
    end
  end

  assign psc_rd  = psc_sh_q;
  assign arr_rd  = arr_sh_q;
  assign ccr1_rd = ccr1_sh_q;
  assign ccr2_rd = ccr2_sh_q;
`else
  always_comb begin
    psc_d  = psc_wr  ? wdata16 : psc_q;
    arr_d  = arr_wr  ? wdata16 : arr_q;
    ccr1_d = ccr1_wr ? wdata16 : ccr1_q;
    ccr2_d = ccr2_wr ? wdata16 : ccr2_q;
  end

  assign psc_rd  = psc_q;
  assign arr_rd  = arr_q;
  assign ccr1_rd = ccr1_q;
  assign ccr2_rd = ccr2_q;
`endif

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (bus_addr)
        A_CR:    rdata_d = {28'd0, cr_q};
        A_SR:    rdata_d = {31'd0, uif_q};
        A_PSC:   rdata_d = {16'd0, psc_rd};
        A_ARR:   rdata_d = {16'd0, arr_rd};
        A_CCR1:  rdata_d = {16'd0, ccr1_rd};
        A_CCR2:  rdata_d = {16'd0, ccr2_rd};
        A_CNT:   rdata_d = {16'd0, tim_cnt};
        default: rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cr_q    <= 4'd0;
      uif_q   <= 1'b0;
      psc_q   <= 16'h0000;
      arr_q   <= ARR_RST;
      ccr1_q  <= 16'h0000;
      ccr2_q  <= 16'h0000;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cr_q    <= cr_d;
      uif_q   <= uif_d;
      psc_q   <= psc_d;
      arr_q   <= arr_d;
      ccr1_q  <= ccr1_d;
      ccr2_q  <= ccr2_d;
      rdata_q <= rdata_d;
      ready_q <= bus_sel;
    end
  end

  assign bus_rdata = rdata_q;
  assign bus_ready = ready_q;
  assign timer_en  = (state_q == ST_RUN);
  assign countdown = cr_q[1];
  assign TIM_PSC   = psc_q;
  assign TIM_ARR   = arr_q;
  assign TIM_CCR1  = ccr1_q;
  assign TIM_CCR2  = ccr2_q;
  assign irq       = uif_q & cr_q[3];

endmodule
